// File: rtl/rx_drain_ctrl.sv
`timescale 1ns/1ps
// Read-side drain controller for the UART receiver: pops bytes from the rx FIFO,
// packs them little-endian into a word and hands the word to a host over valid/ready.
module rx_drain_ctrl #(
    parameter int BPW         = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int TMO_W       = 7
) (
    input  logic        rx_clk,
    input  logic        rst,
    input  logic        ctrl_en,
    input  logic        flush,
    input  logic        rx_empty,
    input  logic [7:0]  rx_data_out,
    output logic        rx_en,
    output logic        rx_req,
    output logic [31:0] word_data,
    output logic [2:0]  word_bytes,
    output logic        word_valid,
    input  logic        word_ready,
    output logic        timeout_flag,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        CAPT = 2'd2,
        EMIT = 2'd3
    } state_t;

    localparam logic [2:0]       BPW_C    = 3'(BPW);
    localparam bit               TMO_ON   = (TIMEOUT_CYC != 0);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = '1;

    state_t           state, state_nx;
    logic [2:0]       cnt, cnt_nx;
    logic [TMO_W-1:0] tmo, tmo_nx;
    logic [31:0]      data_nx;
    logic             tflag_nx;

    // The byte count doubles as the reported word length; it is held stable through EMIT.
    assign word_bytes = cnt;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_nx = state;
        cnt_nx   = cnt;
        tmo_nx   = tmo;
        data_nx  = word_data;
        tflag_nx = timeout_flag;

        unique case (state)
            IDLE: begin
                if (cnt != 3'd0 && flush) begin
                    state_nx = EMIT;
                    tflag_nx = 1'b0;
                end else if (cnt != 3'd0 && TMO_ON && tmo == TMO_LAST) begin
                    state_nx = EMIT;
                    tflag_nx = 1'b1;
                end else if (ctrl_en && !rx_empty) begin
                    state_nx = POP;
                end else if (cnt != 3'd0 && tmo != TMO_MAX) begin
                    tmo_nx = tmo + 1'b1;
                end
            end
            POP: begin
                state_nx = CAPT;
            end
            CAPT: begin
                // FIFO read data is valid here, one cycle after the pop strobe.
                data_nx[{cnt[1:0], 3'b000} +: 8] = rx_data_out;
                cnt_nx   = cnt + 3'd1;
                tmo_nx   = '0;
                tflag_nx = 1'b0;
                state_nx = (cnt_nx == BPW_C) ? EMIT : IDLE;
            end
            EMIT: begin
                if (word_ready) begin
                    state_nx = IDLE;
                    cnt_nx   = 3'd0;
                    tmo_nx   = '0;
                    data_nx  = '0;
                    tflag_nx = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge rx_clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            tmo          <= '0;
            word_data    <= '0;
            timeout_flag <= 1'b0;
            rx_en        <= 1'b0;
            rx_req       <= 1'b0;
            word_valid   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state        <= state_nx;
            cnt          <= cnt_nx;
            tmo          <= tmo_nx;
            word_data    <= data_nx;
            timeout_flag <= tflag_nx;
            rx_en        <= ctrl_en;
            rx_req       <= (state_nx == POP);
            word_valid   <= (state_nx == EMIT);
            busy         <= (state_nx != IDLE) || (cnt_nx != 3'd0);
        end
    end

endmodule
